regfile_mp_scoreboard: RTL and testbench

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard, for the pipelined RISC-V core.
- Serves NRD combinational read ports and NWR write-back ports.
- Tracks which architectural registers have an in-flight producer, so issue logic can stall on RAW hazards.
- Register 0 is hard-wired zero and is never busy.

---
 rtl/rv_core_pkg.sv | 15 +
 rtl/rf_bypass_mux.sv | 46 ++++
 rtl/regfile_mp_scoreboard.sv | 95 +++++++++
 tb/tb_regfile_mp_scoreboard.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared core-wide types and defaults for the integer datapath.
// addr_w() sizes register-index fields from a register count.
package rv_core_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] xlen_t;

   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Read-port selector for one register file port. It forwards same-cycle write-back
// data, with the highest-index write port winning, and forces register 0 to read zero.
module rf_bypass_mux #(
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int NWR    = 2,
   parameter int BYPASS = 1
) (
   input  logic [AW-1:0]       rd_addr,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [XLEN-1:0]     stored_data,
   input  logic                stored_busy,
   output logic [XLEN-1:0]     rd_data,
   output logic                rd_busy
);

   logic            hit;
   logic [XLEN-1:0] fwd_data;

   // The loop runs in ascending order, so the last match is the highest-index port.
   always_comb begin
      hit      = 1'b0;
      fwd_data = '0;
      for (int p = 0; p < NWR; p++) begin
         if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr)) begin
            hit      = 1'b1;
            fwd_data = wr_data[p*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      rd_data = stored_data;
      rd_busy = stored_busy;
      if (rd_addr == '0) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end else if ((BYPASS != 0) && hit) begin
         rd_data = fwd_data;
         rd_busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write-to-read bypass and a busy scoreboard.
// Issue logic uses the scoreboard to stall on RAW hazards. Register 0 always reads zero and is never busy.
module regfile_mp_scoreboard
   import rv_core_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int NREGS     = NREGS_DEFAULT,
   parameter int NRD       = 2,
   parameter int NWR       = 2,
   parameter int BYPASS    = 1,
   parameter int RST_INDEX = 1,
   localparam int AW       = addr_w(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_rd,
   output logic [NREGS-1:0]    busy_vec
);

   if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
      $error("regfile_mp_scoreboard: NREGS must be a power of two >= 2");
   end

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_nxt;

   // Ports are applied in ascending order, so the highest-index port wins a same-address conflict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= (RST_INDEX != 0) ? XLEN'(i) : '0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
               regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
            end
         end
      end
   end

   // Write-back clears the bit first and issue sets it afterwards, so a new producer supersedes the old one.
   always_comb begin
      busy_nxt = busy_q;
      for (int p = 0; p < NWR; p++) begin
         if (wr_en[p]) begin
            busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
         end
      end
      if (issue_en) begin
         busy_nxt[issue_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
      end
   end

   assign busy_vec = busy_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr_k;
      assign addr_k = rd_addr[k*AW +: AW];

      rf_bypass_mux #(
         .XLEN   (XLEN),
         .AW     (AW),
         .NWR    (NWR),
         .BYPASS (BYPASS)
      ) u_mux (
         .rd_addr     (addr_k),
         .wr_en       (wr_en),
         .wr_addr     (wr_addr),
         .wr_data     (wr_data),
         .stored_data (regs[addr_k]),
         .stored_busy (busy_q[addr_k]),
         .rd_data     (rd_data[k*XLEN +: XLEN]),
         .rd_busy     (rd_busy[k])
      );
   end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard. Two instances (BYPASS=1 and BYPASS=0) share one stimulus
// and are compared against an array-based reference model of the register file and scoreboard.
module tb_regfile_mp_scoreboard;
   import rv_core_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                issue_en;
   logic [AW-1:0]       issue_rd;

   logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
   logic [NRD-1:0]      rd_busy_b, rd_busy_n;
   logic [NREGS-1:0]    busy_vec_b, busy_vec_n;

   int checks   = 0;
   int failures = 0;

   xlen_t            m_regs [NREGS];
   logic [NREGS-1:0] m_busy;

   always #5 clk = ~clk;

   regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                           .BYPASS(1), .RST_INDEX(1)) u_dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_vec_b)
   );

   regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                           .BYPASS(0), .RST_INDEX(1)) u_dut_n (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_vec_n)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // The reference read follows the spec rules: zero register, then optional forwarding, then storage.
   function automatic xlen_t exp_data(input int a, input bit byp);
      if (a == 0) return '0;
      if (byp) begin
         for (int p = NWR - 1; p >= 0; p--) begin
            if (wr_en[p] && (int'(wr_addr[p*AW +: AW]) == a)) return wr_data[p*XLEN +: XLEN];
         end
      end
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input int a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp) begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (int'(wr_addr[p*AW +: AW]) == a)) return 1'b0;
         end
      end
      return m_busy[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = xlen_t'(i);
      m_busy = '0;
   endtask

   task automatic model_clock();
      logic [NREGS-1:0] nb;
      for (int i = 1; i < NREGS; i++) begin
         bit set_i, clr_i;
         set_i = issue_en && (int'(issue_rd) == i);
         clr_i = 1'b0;
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (int'(wr_addr[p*AW +: AW]) == i)) clr_i = 1'b1;
         end
         nb[i] = set_i | (m_busy[i] & ~clr_i);
      end
      nb[0] = 1'b0;
      for (int p = 0; p < NWR; p++) begin
         if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) m_regs[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
      end
      m_busy = nb;
   endtask

   task automatic check_all(input string ctx);
      for (int k = 0; k < NRD; k++) begin
         int a;
         a = int'(rd_addr[k*AW +: AW]);
         check($sformatf("%s rd_data_b[%0d] a=%0d", ctx, k, a), 64'(rd_data_b[k*XLEN +: XLEN]), 64'(exp_data(a, 1'b1)));
         check($sformatf("%s rd_busy_b[%0d] a=%0d", ctx, k, a), 64'(rd_busy_b[k]), 64'(exp_busy(a, 1'b1)));
         check($sformatf("%s rd_data_n[%0d] a=%0d", ctx, k, a), 64'(rd_data_n[k*XLEN +: XLEN]), 64'(exp_data(a, 1'b0)));
         check($sformatf("%s rd_busy_n[%0d] a=%0d", ctx, k, a), 64'(rd_busy_n[k]), 64'(exp_busy(a, 1'b0)));
      end
      check($sformatf("%s busy_vec_b", ctx), 64'(busy_vec_b), 64'(m_busy));
      check($sformatf("%s busy_vec_n", ctx), 64'(busy_vec_n), 64'(m_busy));
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      issue_en = 1'b0;
      issue_rd = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      rd_addr = {5'd0, 5'd5};
      model_reset();

      // Reset state with rst still asserted, then after release.
      #7;
      check_all("reset");
      check("reset rd5", 64'(rd_data_b[31:0]), 64'd5);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all("reset_release");

      // Dual write to the same address: port 1 wins, also through the bypass.
      wr_en   = 2'b11;
      wr_addr = {5'd7, 5'd7};
      wr_data = {32'h0000_BBBB, 32'h0000_AAAA};
      rd_addr = {5'd7, 5'd7};
      #1;
      check_all("dual_write");
      check("dual_write bypass", 64'(rd_data_b[31:0]), 64'h0000_BBBB);
      tick();
      idle();
      #1;
      check_all("dual_write_after");
      check("dual_write stored", 64'(rd_data_n[31:0]), 64'h0000_BBBB);

      // Register 0 ignores writes and issues.
      wr_en    = 2'b01;
      wr_addr  = {5'd0, 5'd0};
      wr_data  = {32'h0, 32'h0000_DEAD};
      issue_en = 1'b1;
      issue_rd = 5'd0;
      rd_addr  = {5'd0, 5'd0};
      #1;
      check_all("x0_write");
      tick();
      idle();
      #1;
      check_all("x0_after");
      check("x0 busy", 64'(busy_vec_b[0]), 64'd0);

      // Scoreboard lifecycle on register 3.
      issue_en = 1'b1;
      issue_rd = 5'd3;
      tick();
      idle();
      rd_addr = {5'd0, 5'd3};
      #1;
      check_all("sb_issued");
      check("sb rd_busy set", 64'(rd_busy_b[0]), 64'd1);
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd3};
      wr_data = {32'h0, 32'h0000_1234};
      #1;
      check_all("sb_writeback");
      check("sb wb rd_busy_b", 64'(rd_busy_b[0]), 64'd0);
      check("sb wb rd_data_b", 64'(rd_data_b[31:0]), 64'h0000_1234);
      check("sb wb rd_busy_n", 64'(rd_busy_n[0]), 64'd1);
      tick();
      idle();
      #1;
      check_all("sb_cleared");
      check("sb busy3 cleared", 64'(busy_vec_b[3]), 64'd0);

      // Same-cycle issue and write-back to register 9 keeps it busy.
      issue_en = 1'b1;
      issue_rd = 5'd9;
      wr_en    = 2'b10;
      wr_addr  = {5'd9, 5'd0};
      wr_data  = {32'h0000_0099, 32'h0};
      tick();
      idle();
      rd_addr = {5'd9, 5'd9};
      #1;
      check_all("issue_wb_same");
      check("issue_wb busy9", 64'(busy_vec_b[9]), 64'd1);
      check("issue_wb data9", 64'(rd_data_n[31:0]), 64'h0000_0099);

      // Without bypass, a read sees the old value until the next cycle.
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd4};
      wr_data = {32'h0, 32'h0000_0055};
      rd_addr = {5'd0, 5'd4};
      #1;
      check_all("nobyp_write");
      check("nobyp old", 64'(rd_data_n[31:0]), 64'd4);
      tick();
      idle();
      #1;
      check("nobyp new", 64'(rd_data_n[31:0]), 64'h0000_0055);

      // Asynchronous reset in the middle of pending activity.
      issue_en = 1'b1;
      issue_rd = 5'd12;
      tick();
      wr_en   = 2'b11;
      wr_addr = {5'd12, 5'd5};
      wr_data = {32'hCAFE_0001, 32'hCAFE_0002};
      rd_addr = {5'd5, 5'd12};
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      idle();
      #1;
      check_all("async_reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all("async_reset_release");

      // Randomised traffic, addresses biased low so collisions happen often.
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NRD; k++) begin
            rd_addr[k*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
         end
         wr_en = NWR'($urandom_range(0, 3));
         for (int p = 0; p < NWR; p++) begin
            wr_addr[p*AW +: AW]   = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
            wr_data[p*XLEN +: XLEN] = $urandom;
         end
         issue_en = 1'($urandom_range(0, 1));
         issue_rd = AW'($urandom_range(0, 7));
         #1;
         check_all($sformatf("rand%0d", n));
         tick();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
